// File: rtl/mac_pkg.sv
// Shared types and Q-format constants for the MAC sequencer family.
package mac_pkg;

    localparam int unsigned IWIDTH_DEF = 8;
    localparam int unsigned OWIDTH_DEF = 16;
    localparam int unsigned ACCW_DEF   = 24;
    localparam int unsigned LENW_DEF   = 8;

    localparam logic [7:0]  Q17_NEG_ONE = 8'h80;
    localparam logic [15:0] Q115_MAX    = 16'h7FFF;
    localparam logic [15:0] Q115_MIN    = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } mac_state_t;

endpackage

// File: rtl/mac_saturate.sv
// Clamps a wide signed accumulator into a signed OWIDTH result with an overflow flag.
module mac_saturate #(
    parameter int unsigned ACCW   = 24,
    parameter int unsigned OWIDTH = 16
) (
    input  logic [ACCW-1:0]   acc,
    output logic [OWIDTH-1:0] sat,
    output logic              ovf
);

    logic [ACCW-OWIDTH:0] hi;
    logic                 fits;

    // The value fits when every bit from the result sign upward agrees.
    always_comb begin
        hi   = acc[ACCW-1:OWIDTH-1];
        fits = (&hi) | ~(|hi);
        ovf  = ~fits;
        if (fits) begin
            sat = acc[OWIDTH-1:0];
        end else if (acc[ACCW-1]) begin
            sat = {1'b1, {(OWIDTH-1){1'b0}}};
        end else begin
            sat = {1'b0, {(OWIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mult.sv
// Signed Q1.7 x Q1.7 multiplier producing a Q1.15 product (wraps on -1 x -1).
module mult #(
    parameter int unsigned IWIDTH = 8,
    parameter int unsigned OWIDTH = 16
) (
    input  logic [IWIDTH-1:0] a,
    input  logic [IWIDTH-1:0] b,
    output logic [OWIDTH-1:0] p
);

    logic signed [2*IWIDTH-1:0] full;

    // Full-precision product is Q2.14; one left shift realigns it to Q1.15.
    always_comb begin
        full = $signed(a) * $signed(b);
        p    = OWIDTH'(full << 1);
    end

endmodule

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: streams operand pairs through one multiplier into a
// wide accumulator and returns one saturated Q1.15 result per job.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int unsigned IWIDTH = IWIDTH_DEF,
    parameter int unsigned OWIDTH = OWIDTH_DEF,
    parameter int unsigned ACCW   = ACCW_DEF,
    parameter int unsigned LENW   = LENW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LENW-1:0]   len,
    output logic              busy,
    input  logic [IWIDTH-1:0] a_data,
    input  logic [IWIDTH-1:0] b_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OWIDTH-1:0] res_data,
    output logic              res_ovf,
    output logic              res_valid,
    input  logic              res_ready
);

    localparam logic [IWIDTH-1:0] NEG_ONE  = {1'b1, {(IWIDTH-1){1'b0}}};
    localparam logic [OWIDTH-1:0] PROD_MAX = {1'b0, {(OWIDTH-1){1'b1}}};

    mac_state_t        state_q, state_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic [LENW-1:0]   cnt_q, cnt_d;
    logic [LENW-1:0]   len_q, len_d;
    logic [OWIDTH-1:0] prod_q, prod_d;
    logic              prod_v_q, prod_v_d;
    logic [OWIDTH-1:0] res_data_q, res_data_d;
    logic              res_ovf_q, res_ovf_d;

    logic [OWIDTH-1:0] mult_p;
    logic [OWIDTH-1:0] prod_fix;
    logic [OWIDTH-1:0] sat_data;
    logic              sat_ovf;

    mult #(
        .IWIDTH(IWIDTH),
        .OWIDTH(OWIDTH)
    ) u_mult (
        .a(a_data),
        .b(b_data),
        .p(mult_p)
    );

    mac_saturate #(
        .ACCW(ACCW),
        .OWIDTH(OWIDTH)
    ) u_sat (
        .acc(acc_q),
        .sat(sat_data),
        .ovf(sat_ovf)
    );

    // Replace the wrapped -1 x -1 product with the largest positive value.
    always_comb begin
        if (a_data == NEG_ONE && b_data == NEG_ONE) begin
            prod_fix = PROD_MAX;
        end else begin
            prod_fix = mult_p;
        end
    end

    // Next-state logic: job control, product pipeline and accumulation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        prod_d     = prod_q;
        prod_v_d   = 1'b0;
        res_data_d = res_data_q;
        res_ovf_d  = res_ovf_q;
        if (prod_v_q) begin
            acc_d = acc_q + {{(ACCW-OWIDTH){prod_q[OWIDTH-1]}}, prod_q};
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    cnt_d = '0;
                    if (len != '0) begin
                        len_d   = len;
                        state_d = RUN;
                    end else begin
                        res_data_d = '0;
                        res_ovf_d  = 1'b0;
                        state_d    = DONE;
                    end
                end
            end
            RUN: begin
                if (in_valid) begin
                    prod_d   = prod_fix;
                    prod_v_d = 1'b1;
                    cnt_d    = cnt_q + LENW'(1);
                    if (cnt_q + LENW'(1) == len_q) begin
                        state_d = FLUSH;
                    end
                end
            end
            // FLUSH spends one cycle folding in the last product and a second
            // cycle registering the clamped result, so the output is a flop.
            FLUSH: begin
                if (!prod_v_q) begin
                    res_data_d = sat_data;
                    res_ovf_d  = sat_ovf;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            prod_q     <= '0;
            prod_v_q   <= 1'b0;
            res_data_q <= '0;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            prod_q     <= prod_d;
            prod_v_q   <= prod_v_d;
            res_data_q <= res_data_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

    // Handshake outputs decode directly from the registered state.
    always_comb begin
        busy      = (state_q != IDLE);
        in_ready  = (state_q == RUN);
        res_valid = (state_q == DONE);
        res_data  = res_data_q;
        res_ovf   = res_ovf_q;
    end

endmodule
